// File: rtl/mem_stage.sv
// Data-memory stage: single-outstanding load/store handshake with a bounded
// wait for mem_ack, alignment checking, and a held load register for write-back.
module mem_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ALUOut,
    input  logic [31:0] StoreData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic [31:0] WBData,
    output logic        load_valid,
    output logic        mem_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [31:0] r_load;

    logic w_access;
    logic w_illegal;
    logic w_accept;
    logic w_timeout;

    assign w_access  = MemRead ^ MemWrite;
    assign w_illegal = (MemRead & MemWrite) | (w_access & (ALUOut[1:0] != 2'b00));
    assign w_accept  = (r_state == S_IDLE) & w_access & ~w_illegal;
    assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // mem_ack takes priority over the timeout when both land on the same cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_illegal) begin
                    w_next = S_ERR;
                end else if (w_access) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    w_next = S_DONE;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 8'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_we    <= 1'b0;
            r_load  <= 32'd0;
        end else begin
            if (w_accept) begin
                r_cnt   <= 8'd0;
                r_addr  <= ALUOut;
                r_wdata <= StoreData;
                r_we    <= MemWrite;
            end else if (r_state == S_REQ) begin
                if (mem_ack) begin
                    if (!r_we) begin
                        r_load <= mem_rdata;
                    end
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    // Handshake outputs decode registered state only; nothing flows from mem_ack
    assign mem_req    = (r_state == S_REQ);
    assign mem_we     = (r_state == S_REQ) & r_we;
    assign mem_addr   = (r_state == S_REQ) ? r_addr  : 32'd0;
    assign mem_wdata  = (r_state == S_REQ) ? r_wdata : 32'd0;
    assign load_valid = (r_state == S_DONE) & ~r_we;
    assign mem_err    = (r_state == S_ERR);
    assign stall      = w_accept | (r_state == S_REQ);
    assign WBData     = MemtoReg ? r_load : ALUOut;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: each instruction is scored against a
// transaction-level model (ack latency -> REQ length -> DONE/ERR outcome).
module tb_mem_stage;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ALUOut, StoreData, mem_rdata;
    logic        MemRead, MemWrite, MemtoReg, mem_ack;
    logic        mem_req, mem_we, stall, load_valid, mem_err;
    logic [31:0] mem_addr, mem_wdata, WBData;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_load = 32'd0;

    mem_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ALUOut(ALUOut), .StoreData(StoreData),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .WBData(WBData),
        .load_valid(load_valid), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        MemtoReg  = 1'b0;
        mem_ack   = 1'b0;
        ALUOut    = $urandom;
        StoreData = $urandom;
        mem_rdata = $urandom;
    endtask

    // k = REQ cycle (1-based) on which ack arrives; k > TO means it never does.
    task automatic xact(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] sd, input int k, input logic [31:0] ackd);
        logic acc, ill;
        int   n;
        acc = rd ^ wr;
        ill = (rd & wr) | (acc & (addr[1:0] != 2'b00));
        MemRead = rd; MemWrite = wr; ALUOut = addr; StoreData = sd; MemtoReg = 1'b0;
        mem_ack = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #1;
        chk("stall_issue", {31'd0, stall}, {31'd0, acc & ~ill});
        chk("req_idle", {31'd0, mem_req}, 32'd0);
        chk("wb_alu", WBData, addr);
        @(negedge clk);
        if (ill) begin
            chk("err_illegal", {31'd0, mem_err}, 32'd1);
            chk("req_illegal", {31'd0, mem_req}, 32'd0);
            chk("stall_err", {31'd0, stall}, 32'd0);
            chk("lv_illegal", {31'd0, load_valid}, 32'd0);
        end else if (acc) begin
            n = (k < TO) ? k : TO;
            for (int i = 1; i <= n; i++) begin
                chk("req_hi", {31'd0, mem_req}, 32'd1);
                chk("req_we", {31'd0, mem_we}, {31'd0, wr});
                chk("req_addr", mem_addr, addr);
                chk("req_wdata", mem_wdata, sd);
                chk("req_stall", {31'd0, stall}, 32'd1);
                chk("req_nopulse", {30'd0, load_valid, mem_err}, 32'd0);
                mem_ack   = (i == k);
                mem_rdata = (i == k) ? ackd : $urandom;
                ALUOut    = $urandom;
                StoreData = $urandom;
                MemRead   = 1'($urandom_range(0, 1));
                MemWrite  = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            if (k <= TO) begin
                chk("done_lv", {31'd0, load_valid}, {31'd0, rd});
                chk("done_err", {31'd0, mem_err}, 32'd0);
                if (rd) m_load = ackd;
            end else begin
                chk("to_err", {31'd0, mem_err}, 32'd1);
                chk("to_lv", {31'd0, load_valid}, 32'd0);
            end
            chk("end_req", {31'd0, mem_req}, 32'd0);
            chk("end_addr", mem_addr, 32'd0);
            chk("end_wdata", mem_wdata, 32'd0);
            // A legal access presented in DONE/ERR must not stall
            MemRead = 1'b1; MemWrite = 1'b0; ALUOut = 32'h0000_0010;
            mem_ack = 1'($urandom_range(0, 1));
            #1;
            chk("end_stall", {31'd0, stall}, 32'd0);
        end else begin
            chk("noacc_req", {31'd0, mem_req}, 32'd0);
            chk("noacc_pulse", {30'd0, load_valid, mem_err}, 32'd0);
            chk("noacc_stall", {31'd0, stall}, 32'd0);
        end
        MemtoReg = 1'b1;
        #1;
        chk("wb_load", WBData, m_load);
        idle_inputs();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic rd, wr;
        logic [31:0] a;
        idle_inputs();
        MemtoReg = 1'b1;
        #2;
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_pulses", {30'd0, load_valid, mem_err}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_load", WBData, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // first access right after release, then the directed scenarios
        xact(1'b1, 1'b0, 32'h100, 32'h0, 3, 32'hDEAD_BEEF);
        xact(1'b0, 1'b1, 32'h40, 32'h1234_5678, 1, 32'hFFFF_FFFF);
        xact(1'b1, 1'b0, 32'h102, 32'h0, 1, 32'h0);
        xact(1'b0, 1'b1, 32'h80, 32'hCAFE_F00D, TO + 1, 32'h0);
        xact(1'b1, 1'b0, 32'h84, 32'h0, TO, 32'h5A5A_A5A5);
        xact(1'b1, 1'b1, 32'h88, 32'h0, 1, 32'h0);
        xact(1'b0, 1'b0, 32'h8C, 32'h0, 1, 32'h0);

        // reset on the 2nd REQ cycle of a read
        MemRead = 1'b1; ALUOut = 32'h200;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        chk("mid_req_hi", {31'd0, mem_req}, 32'd1);
        idle_inputs();
        #1 rst_n = 1'b0;
        m_load = 32'd0;
        #1;
        chk("mid_req_drop", {31'd0, mem_req}, 32'd0);
        chk("mid_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        chk("mid_nopulse_rst", {30'd0, load_valid, mem_err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_nopulse", {30'd0, load_valid, mem_err}, 32'd0);
        chk("mid_req_after", {31'd0, mem_req}, 32'd0);
        MemtoReg = 1'b1;
        #1;
        chk("mid_load0", WBData, 32'd0);
        idle_inputs();
        @(negedge clk);

        for (int t = 0; t < 80; t++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            xact(rd, wr, a, $urandom, $urandom_range(1, TO + 2), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
